// File: rtl/memory_arbiter_pkg.sv
// Shared types and the tie-break helper for the instruction/data memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } bus_req_t;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Pick the next owner from the current requests. On a tie, data wins when
  // prioritised, otherwise the requester that was not served last wins.
  function automatic arb_state_t arb_pick(input logic i_pend, input logic d_pend,
                                          input bus_req_t last, input logic data_prio);
    if (i_pend && d_pend) begin
      return (data_prio || (last == REQ_INSTR)) ? ARB_GNT_D : ARB_GNT_I;
    end
    if (d_pend) return ARB_GNT_D;
    if (i_pend) return ARB_GNT_I;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Simple request/busy memory bus shared by requesters, arbiter and memory.
interface generic_bus_if #(
  parameter int BLOCK_SIZE = 1
);
  logic [31:0]              addr;
  logic                     ren;
  logic                     wen;
  logic [32*BLOCK_SIZE-1:0] wdata;
  logic [3:0]               byte_en;
  logic [32*BLOCK_SIZE-1:0] rdata;
  logic                     busy;
  logic                     error;

  modport generic_bus (
    input  addr, ren, wen, wdata, byte_en,
    output rdata, busy, error
  );

  modport cpu (
    output addr, ren, wen, wdata, byte_en,
    input  rdata, busy, error
  );
endinterface

// File: rtl/memory_arbiter_mux.sv
// Combinational routing of the two requester ports onto the shared memory port.
module generic_bus_mux
  import memory_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE = 1
) (
  input  logic [1:0]          i_grant,
  generic_bus_if.generic_bus  ibus,
  generic_bus_if.generic_bus  dbus,
  generic_bus_if.cpu          mbus
);

  localparam logic [WORD_W*BLOCK_SIZE-1:0] ZERO_DATA = '0;

  // Route the granted requester through; idle bus and stalled requesters otherwise.
  always_comb begin
    mbus.addr    = '0;
    mbus.ren     = 1'b0;
    mbus.wen     = 1'b0;
    mbus.wdata   = ZERO_DATA;
    mbus.byte_en = '0;
    ibus.rdata   = ZERO_DATA;
    ibus.busy    = 1'b1;
    ibus.error   = 1'b0;
    dbus.rdata   = ZERO_DATA;
    dbus.busy    = 1'b1;
    dbus.error   = 1'b0;
    if (i_grant[0]) begin
      mbus.addr    = ibus.addr;
      mbus.ren     = ibus.ren;
      mbus.wen     = ibus.wen;
      mbus.wdata   = ibus.wdata;
      mbus.byte_en = ibus.byte_en;
      ibus.rdata   = mbus.rdata;
      ibus.busy    = mbus.busy;
      ibus.error   = mbus.error;
    end else if (i_grant[1]) begin
      mbus.addr    = dbus.addr;
      mbus.ren     = dbus.ren;
      mbus.wen     = dbus.wen;
      mbus.wdata   = dbus.wdata;
      mbus.byte_en = dbus.byte_en;
      dbus.rdata   = mbus.rdata;
      dbus.busy    = mbus.busy;
      dbus.error   = mbus.error;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-to-one arbiter: instruction and data requesters share one memory port.
// The grant is held until memory completes; a new owner is picked on the
// completion cycle so back-to-back transfers and handoffs need no idle cycle.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE    = 1,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  generic_bus_if.generic_bus ibus,
  generic_bus_if.generic_bus dbus,
  generic_bus_if.cpu         mbus,
  output logic [1:0]         grant
);

  arb_state_t r_state;
  arb_state_t w_next;
  bus_req_t   r_last;
  bus_req_t   w_last_next;
  logic       w_i_pend;
  logic       w_d_pend;

  assign w_i_pend = ibus.ren | ibus.wen;
  assign w_d_pend = dbus.ren | dbus.wen;
  assign grant    = {r_state == ARB_GNT_D, r_state == ARB_GNT_I};

  // Next owner: arbitrate from idle, hold until completion, drop on abort.
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    case (r_state)
      ARB_IDLE: w_next = arb_pick(w_i_pend, w_d_pend, r_last, DATA_PRIORITY);
      ARB_GNT_I: begin
        if (!w_i_pend) begin
          w_next = ARB_IDLE;
        end else if (!mbus.busy) begin
          w_last_next = REQ_INSTR;
          w_next      = arb_pick(w_i_pend, w_d_pend, REQ_INSTR, DATA_PRIORITY);
        end
      end
      ARB_GNT_D: begin
        if (!w_d_pend) begin
          w_next = ARB_IDLE;
        end else if (!mbus.busy) begin
          w_last_next = REQ_DATA;
          w_next      = arb_pick(w_i_pend, w_d_pend, REQ_DATA, DATA_PRIORITY);
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // State and last-served registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ARB_IDLE;
      r_last  <= REQ_INSTR;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end

  generic_bus_mux #(
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_mux (
    .i_grant (grant),
    .ibus    (ibus),
    .dbus    (dbus),
    .mbus    (mbus)
  );

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: one round-robin and one data-priority instance
// driven by the same requesters and memory, each checked every cycle against
// a requester-level ownership model, plus directed scenario checks.
module tb_memory_arbiter;

  localparam int VW = 140;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] t_iaddr = '0, t_iwdata = '0, t_daddr = '0, t_dwdata = '0, t_mrdata = '0;
  logic        t_iren = 1'b0, t_iwen = 1'b0, t_dren = 1'b0, t_dwen = 1'b0;
  logic [3:0]  t_ibe = '0, t_dbe = '0;
  logic        t_mbusy = 1'b1, t_merr = 1'b0;

  logic [1:0]    gnt [2];
  logic [VW-1:0] obs [2];

  int total = 0;
  int bad   = 0;

  // Model: owner 0 = nobody, 1 = instr, 2 = data; last 0 = instr, 1 = data.
  int m_own  [2];
  int m_last [2];
  bit m_valid = 1'b0;

  always #5 CLK = ~CLK;

  for (genvar p = 0; p < 2; p++) begin : g
    generic_bus_if #(.BLOCK_SIZE(1)) ib ();
    generic_bus_if #(.BLOCK_SIZE(1)) db ();
    generic_bus_if #(.BLOCK_SIZE(1)) mb ();

    assign ib.addr = t_iaddr;  assign ib.ren = t_iren;  assign ib.wen = t_iwen;
    assign ib.wdata = t_iwdata; assign ib.byte_en = t_ibe;
    assign db.addr = t_daddr;  assign db.ren = t_dren;  assign db.wen = t_dwen;
    assign db.wdata = t_dwdata; assign db.byte_en = t_dbe;
    assign mb.rdata = t_mrdata; assign mb.busy = t_mbusy; assign mb.error = t_merr;

    memory_arbiter #(.BLOCK_SIZE(1), .DATA_PRIORITY(p == 1)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .ibus  (ib),
      .dbus  (db),
      .mbus  (mb),
      .grant (gnt[p])
    );

    assign obs[p] = {gnt[p], mb.addr, mb.ren, mb.wen, mb.wdata, mb.byte_en,
                     ib.rdata, ib.busy, ib.error, db.rdata, db.busy, db.error};
  end

  task automatic chk(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic int pick(input bit pi, input bit pd, input int last, input int prio);
    if (pi && pd) return (prio == 1 || last == 0) ? 2 : 1;
    if (pd) return 2;
    if (pi) return 1;
    return 0;
  endfunction

  // What the bus must look like given who owns it and the current inputs.
  function automatic logic [VW-1:0] expect_vec(input int own);
    if (own == 1)
      return {2'b01, t_iaddr, t_iren, t_iwen, t_iwdata, t_ibe,
              t_mrdata, t_mbusy, t_merr, 32'h0, 1'b1, 1'b0};
    if (own == 2)
      return {2'b10, t_daddr, t_dren, t_dwen, t_dwdata, t_dbe,
              32'h0, 1'b1, 1'b0, t_mrdata, t_mbusy, t_merr};
    return {2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0,
            32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
  endfunction

  task automatic model_step();
    bit pi, pd, mine;
    pi = t_iren | t_iwen;
    pd = t_dren | t_dwen;
    for (int p = 0; p < 2; p++) begin
      if (RST) begin
        m_own[p]  = 0;
        m_last[p] = 0;
      end else if (m_own[p] == 0) begin
        m_own[p] = pick(pi, pd, m_last[p], p);
      end else begin
        mine = (m_own[p] == 1) ? pi : pd;
        if (!mine) begin
          m_own[p] = 0;
        end else if (!t_mbusy) begin
          m_last[p] = m_own[p] - 1;
          m_own[p]  = pick(pi, pd, m_last[p], p);
        end
      end
    end
    if (RST) m_valid = 1'b1;
  endtask

  // Check both instances mid-cycle, then advance one clock and the model.
  task automatic tick();
    #2;
    if (m_valid) begin
      chk("model_rr", obs[0], expect_vec(m_own[0]));
      chk("model_prio", obs[1], expect_vec(m_own[1]));
    end
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    // Reset with both requesters pending.
    RST = 1'b1; t_iren = 1'b1; t_dren = 1'b1; t_iaddr = 32'h40; t_daddr = 32'h80;
    repeat (3) tick();
    chk("rst_grant", gnt[0], 2'b00);
    chk("rst_mbus_ren", g[0].mb.ren, 1'b0);
    chk("rst_ibusy", g[0].ib.busy, 1'b1);
    chk("rst_dbusy", g[0].db.busy, 1'b1);

    // Release: first tie goes to data in both modes; then continuous contention.
    RST = 1'b0; t_mbusy = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_alternate", gnt[0], (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("prio_data_wins", gnt[1], 2'b10);
      tick();
    end
    t_iren = 1'b0; t_dren = 1'b0;
    tick();
    chk("idle_after_contention", gnt[0], 2'b00);

    // Single read with two wait cycles.
    t_iren = 1'b1; t_iaddr = 32'h100; t_mbusy = 1'b1;
    tick();
    chk("read_grant", gnt[0], 2'b01);
    chk("read_addr", g[0].mb.addr, 32'h100);
    tick();
    tick();
    t_mbusy = 1'b0; t_mrdata = 32'hDEADBEEF;
    #1;
    chk("read_ibusy", g[0].ib.busy, 1'b0);
    chk("read_rdata", g[0].ib.rdata, 32'hDEADBEEF);
    chk("read_dbusy", g[0].db.busy, 1'b1);
    tick();
    t_iren = 1'b0; t_mbusy = 1'b1;
    tick();
    chk("read_back_idle", gnt[0], 2'b00);

    // Write pass-through with an error at completion.
    t_dwen = 1'b1; t_daddr = 32'h200; t_dwdata = 32'h12345678; t_dbe = 4'b0011;
    tick();
    chk("wr_wdata", g[0].mb.wdata, 32'h12345678);
    chk("wr_be", g[0].mb.byte_en, 4'b0011);
    chk("wr_wen", g[0].mb.wen, 1'b1);
    t_mbusy = 1'b0; t_merr = 1'b1;
    #1;
    chk("wr_error", g[0].db.error, 1'b1);
    chk("wr_dbusy", g[0].db.busy, 1'b0);
    tick();
    t_dwen = 1'b0; t_merr = 1'b0; t_mbusy = 1'b1;
    tick();

    // Abort: granted instr drops its read while memory is busy.
    t_iren = 1'b1;
    tick();
    chk("abort_grant_i", gnt[0], 2'b01);
    t_iren = 1'b0; t_dren = 1'b1;
    tick();
    chk("abort_idle", gnt[0], 2'b00);
    tick();
    chk("abort_then_d", gnt[0], 2'b10);

    // Reset in the middle of a data write.
    t_dren = 1'b0; t_dwen = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_mid_grant", gnt[0], 2'b00);
    chk("rst_mid_wen", g[0].mb.wen, 1'b0);
    t_dwen = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      t_iren   = ($urandom_range(0, 3) == 0);
      t_iwen   = ($urandom_range(0, 5) == 0);
      t_dren   = ($urandom_range(0, 3) == 0);
      t_dwen   = ($urandom_range(0, 4) == 0);
      t_iaddr  = $urandom;  t_daddr  = $urandom;
      t_iwdata = $urandom;  t_dwdata = $urandom;
      t_ibe    = 4'($urandom); t_dbe   = 4'($urandom);
      t_mrdata = $urandom;
      t_mbusy  = ($urandom_range(0, 2) != 0);
      t_merr   = ($urandom_range(0, 7) == 0);
      RST      = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
